i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per bus input (2..4).
REQ-002 SHALL have port CLK  in  1  system clock; all logic posedge; CLK >= 8x SCL rate.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port I2COAR  in  16  own address, [6:0] used.
REQ-005 SHALL have port I2CDXR  in  16  transmit data, [7:0] used.
REQ-006 SHALL have port din_write  in  1  one-CLK pulse: capture I2CDXR[7:0] into tx buffer.
REQ-007 SHALL have port dout_read  in  1  one-CLK pulse: host consumed I2CDRR.
REQ-008 SHALL have port I2CDRR  out  16  last received byte in [7:0]; [15:8]=0.
REQ-009 SHALL have port I2CSTR  out  16  status: [14] SDIR (1=slave transmitting), [12] BB, [11] ROVR, [10] XUNF, [9] AAS, [8] AD0, [5] SCD, [4] XRDY, [3] RRDY, [1] NACKRCVD; others 0.
REQ-010 SHALL have port i2c_scl  in  1  bus clock; no clock stretching.
REQ-011 SHALL have port i2c_sda  inout  1  open-drain: drives 0 or z, never 1.

Function
REQ-012 SHALL synchronize SCL/SDA through SYNC_STAGES flops and detect edges on synchronized values.
REQ-013 SHALL detect START on SDA fall with SCL high and STOP on SDA rise with SCL high, in any state.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, IGNORE.
REQ-015 START (including repeated START) SHALL enter ADDR, clear bit count, set BB, and clear SCD/NACKRCVD/ROVR/XUNF/AAS/AD0.
REQ-016 STOP SHALL enter IDLE, release SDA, set SCD, clear BB.
REQ-017 ADDR SHALL shift SDA MSB-first on 8 SCL rising edges; bit 0 is R/W.
REQ-018 On match with I2COAR[6:0] it SHALL enter ADDR_ACK with AAS=1 and SDIR=R/W. Address 0 with W SHALL be ACKed as a write with AD0=1. Any other address SHALL enter IGNORE without driving SDA.
REQ-019 ACK/NACK drive SHALL start one CLK after the synchronized SCL falling edge following the 8th bit. It SHALL be held until the next synchronized SCL falling edge.
REQ-020 WDATA SHALL sample 8 bits, then WACK. If RRDY=0: copy byte to I2CDRR, set RRDY, ACK. If RRDY=1: keep I2CDRR, set ROVR, NACK, enter IGNORE.
REQ-021 The tx shift register SHALL load from the tx buffer when entering RDATA, and XRDY SHALL be set. If XRDY was already 1, it SHALL load 0xFF and set XUNF.
REQ-022 RDATA SHALL drive bit 7 first, each bit one CLK after SCL falling. It SHALL release SDA after bit 0, then enter RACK.
REQ-023 RACK SHALL sample SDA on SCL rising. 0 SHALL go to RDATA. 1 SHALL set NACKRCVD and enter IGNORE.
REQ-024 din_write SHALL clear XRDY. If it coincides with a shift-register load, the new I2CDXR value SHALL be loaded and XRDY SHALL end at 1.
REQ-025 dout_read SHALL clear RRDY. If it coincides with a byte commit, the commit SHALL win and RRDY SHALL end at 1.
REQ-026 I2CSTR SHALL be registered and reflect state one CLK after the causing event.

Reset
REQ-027 Reset SHALL force IDLE and release SDA asynchronously, including mid-byte.
REQ-028 Reset SHALL clear I2CDRR, the tx buffer and synchronizers to 1, and set I2CSTR=0x0010 (XRDY=1).
REQ-029 After reset release the block SHALL ignore the bus until a fresh START.

Structure
REQ-030 Shared package i2c_pkg SHALL hold the state enum, I2CSTR bit-index constants and STR_RESET=16'h0010.
REQ-031 A sub-module i2c_sync_edge SHALL be used, holding the synchronizer plus rise/fall detect, instantiated for SCL and SDA.

Verification
REQ-032 OAR=0x50; master writes 0xA0,0x3C then STOP -> ACK, I2CDRR=0x003C, RRDY=1, SCD=1, BB=0.
REQ-033 OAR=0x50; host writes I2CDXR=0x5A then 0xC3; master reads 2 bytes, ACK then NACK -> bus bytes 0x5A,0xC3; NACKRCVD=1; XRDY=1.
REQ-034 Address 0x51 W with OAR=0x50 -> SDA never driven low, AAS=0, state IGNORE until STOP.
REQ-035 Two written bytes without dout_read -> second NACKed, ROVR=1, I2CDRR holds first byte.
REQ-036 Read with no din_write -> 0xFF on bus, XUNF=1.
REQ-037 Assert reset during 4th data bit of a write -> SDA released same cycle, I2CSTR=0x0010; next transfer works.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : i2c_pkg                                                          |
// | Purpose : Shared state encoding, status bit map and helpers for i2c_slave. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WDATA    = 3'd3,
    ST_WACK     = 3'd4,
    ST_RDATA    = 3'd5,
    ST_RACK     = 3'd6,
    ST_IGNORE   = 3'd7
  } i2c_state_t;

  localparam int STR_SDIR     = 14;
  localparam int STR_BB       = 12;
  localparam int STR_ROVR     = 11;
  localparam int STR_XUNF     = 10;
  localparam int STR_AAS      = 9;
  localparam int STR_AD0      = 8;
  localparam int STR_SCD      = 5;
  localparam int STR_XRDY     = 4;
  localparam int STR_RRDY     = 3;
  localparam int STR_NACKRCVD = 1;

  localparam logic [15:0] STR_RESET = 16'h0010;

  // A host write landing on the load cycle takes precedence; an empty buffer
  // (XRDY still set) yields the all-ones underflow byte.
  function automatic logic [7:0] tx_pick(input logic       wr_now,
                                         input logic [7:0] dxr,
                                         input logic       xrdy,
                                         input logic [7:0] txbuf);
    logic [7:0] v;
    if (wr_now)    v = dxr;
    else if (xrdy) v = 8'hFF;
    else           v = txbuf;
    return v;
  endfunction

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : i2c_sync_edge                                                    |
// | Purpose : Bus-line synchronizer with rise/fall strobes on the synced value.|
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [2:0] c_FLUSH_CNT = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_prev;
  logic [2:0]             r_flush;
  logic                   w_valid;

  // Edges are masked until the chain has flushed its reset ones, so a bus that
  // is already low at reset release cannot fake a START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '1;
      r_prev  <= 1'b1;
      r_flush <= 3'd0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
      r_prev  <= r_chain[SYNC_STAGES-1];
      if (r_flush != c_FLUSH_CNT)
        r_flush <= r_flush + 3'd1;
    end
  end

  assign w_valid = (r_flush == c_FLUSH_CNT);
  assign o_q     = r_chain[SYNC_STAGES-1];
  assign o_rise  = w_valid &  o_q & ~r_prev;
  assign o_fall  = w_valid & ~o_q &  r_prev;

endmodule : i2c_sync_edge
`default_nettype wire

// File: rtl/i2c_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : i2c_slave                                                        |
// | Purpose : 7-bit address I2C slave, register-style host interface.          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module i2c_slave
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] I2COAR,
  input  logic [15:0] I2CDXR,
  input  logic        din_write,
  input  logic        dout_read,
  output logic [15:0] I2CDRR,
  output logic [15:0] I2CSTR,
  input  logic        i2c_scl,
  inout  wire         i2c_sda
);

  i2c_state_t  r_state;
  logic [3:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_txbuf;
  logic [7:0]  r_drr;
  logic [15:0] r_str;
  logic        r_sda_low;

  logic        w_scl_q, w_scl_rise, w_scl_fall;
  logic        w_sda_q, w_sda_rise, w_sda_fall;
  logic        w_start, w_stop;
  logic        w_addr_match, w_gencall;
  logic        w_do_load;
  logic [7:0]  w_load_byte;
  logic        w_unused;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
    .clk    (CLK),
    .rst_n  (reset),
    .i_d    (i2c_scl),
    .o_q    (w_scl_q),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
    .clk    (CLK),
    .rst_n  (reset),
    .i_d    (i2c_sda),
    .o_q    (w_sda_q),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  assign w_start      = w_sda_fall & w_scl_q;
  assign w_stop       = w_sda_rise & w_scl_q;
  assign w_addr_match = (r_shift[7:1] == I2COAR[6:0]);
  assign w_gencall    = (r_shift == 8'h00);
  assign w_load_byte  = tx_pick(din_write, I2CDXR[7:0], r_str[STR_XRDY], r_txbuf);

  // Transmit byte is fetched on the SCL fall that opens the first data bit.
  assign w_do_load = w_scl_fall & ~w_start & ~w_stop &
                     (((r_state == ST_ADDR_ACK) & r_str[STR_SDIR]) |
                      ((r_state == ST_RDATA) & (r_bitcnt == 4'd0)));

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_bitcnt  <= 4'd0;
      r_shift   <= 8'h00;
      r_txbuf   <= 8'h00;
      r_drr     <= 8'h00;
      r_str     <= STR_RESET;
      r_sda_low <= 1'b0;
    end else begin
      if (din_write) begin
        r_txbuf          <= I2CDXR[7:0];
        r_str[STR_XRDY]  <= 1'b0;
      end
      if (dout_read)
        r_str[STR_RRDY]  <= 1'b0;

      if (w_start) begin
        r_state             <= ST_ADDR;
        r_bitcnt            <= 4'd0;
        r_sda_low           <= 1'b0;
        r_str[STR_BB]       <= 1'b1;
        r_str[STR_SCD]      <= 1'b0;
        r_str[STR_NACKRCVD] <= 1'b0;
        r_str[STR_ROVR]     <= 1'b0;
        r_str[STR_XUNF]     <= 1'b0;
        r_str[STR_AAS]      <= 1'b0;
        r_str[STR_AD0]      <= 1'b0;
      end else if (w_stop) begin
        r_state        <= ST_IDLE;
        r_sda_low      <= 1'b0;
        r_str[STR_SCD] <= 1'b1;
        r_str[STR_BB]  <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR: begin
            if (w_scl_rise && r_bitcnt != 4'd8) begin
              r_shift  <= {r_shift[6:0], w_sda_q};
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_scl_fall && r_bitcnt == 4'd8) begin
              if (w_addr_match) begin
                r_state         <= ST_ADDR_ACK;
                r_sda_low       <= 1'b1;
                r_str[STR_AAS]  <= 1'b1;
                r_str[STR_SDIR] <= r_shift[0];
              end else if (w_gencall) begin
                r_state         <= ST_ADDR_ACK;
                r_sda_low       <= 1'b1;
                r_str[STR_AAS]  <= 1'b1;
                r_str[STR_AD0]  <= 1'b1;
                r_str[STR_SDIR] <= 1'b0;
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (r_str[STR_SDIR]) begin
                r_state <= ST_RDATA;
              end else begin
                r_state   <= ST_WDATA;
                r_sda_low <= 1'b0;
                r_bitcnt  <= 4'd0;
              end
            end
          end

          ST_WDATA: begin
            if (w_scl_rise && r_bitcnt != 4'd8) begin
              r_shift  <= {r_shift[6:0], w_sda_q};
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_scl_fall && r_bitcnt == 4'd8) begin
              if (!r_str[STR_RRDY]) begin
                r_drr           <= r_shift;
                r_str[STR_RRDY] <= 1'b1;
                r_sda_low       <= 1'b1;
                r_state         <= ST_WACK;
              end else begin
                // Previous byte not yet consumed: keep it and refuse this one.
                r_str[STR_ROVR] <= 1'b1;
                r_state         <= ST_IGNORE;
              end
            end
          end

          ST_WACK: begin
            if (w_scl_fall) begin
              r_sda_low <= 1'b0;
              r_bitcnt  <= 4'd0;
              r_state   <= ST_WDATA;
            end
          end

          ST_RDATA: begin
            if (w_scl_fall && r_bitcnt != 4'd0) begin
              if (r_bitcnt == 4'd8) begin
                r_sda_low <= 1'b0;
                r_state   <= ST_RACK;
              end else begin
                r_shift   <= {r_shift[6:0], 1'b0};
                r_sda_low <= ~r_shift[6];
                r_bitcnt  <= r_bitcnt + 4'd1;
              end
            end
          end

          ST_RACK: begin
            if (w_scl_rise) begin
              if (!w_sda_q) begin
                r_state  <= ST_RDATA;
                r_bitcnt <= 4'd0;
              end else begin
                r_str[STR_NACKRCVD] <= 1'b1;
                r_state             <= ST_IGNORE;
              end
            end
          end

          default: ;
        endcase

        if (w_do_load) begin
          r_shift         <= w_load_byte;
          r_sda_low       <= ~w_load_byte[7];
          r_bitcnt        <= 4'd1;
          r_str[STR_XRDY] <= 1'b1;
          if (!din_write && r_str[STR_XRDY])
            r_str[STR_XUNF] <= 1'b1;
        end
      end
    end
  end

  assign i2c_sda  = r_sda_low ? 1'b0 : 1'bz;
  assign I2CDRR   = {8'h00, r_drr};
  assign I2CSTR   = r_str;
  assign w_unused = &{1'b0, I2COAR[15:7], I2CDXR[15:8]};

endmodule : i2c_slave
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_i2c_slave                                                     |
// | Purpose : Directed bus-master bench with queued expectations for i2c_slave.|
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_i2c_slave;

  localparam int Q = 40;

  logic        CLK = 1'b0;
  logic        reset;
  logic [15:0] I2COAR, I2CDXR;
  logic        din_write, dout_read;
  wire  [15:0] I2CDRR, I2CSTR;
  logic        i2c_scl;
  logic        m_sda_low;
  wire         i2c_sda;

  assign i2c_sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (i2c_sda);

  i2c_slave #(.SYNC_STAGES(2)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .I2COAR    (I2COAR),
    .I2CDXR    (I2CDXR),
    .din_write (din_write),
    .dout_read (dout_read),
    .I2CDRR    (I2CDRR),
    .I2CSTR    (I2CSTR),
    .i2c_scl   (i2c_scl),
    .i2c_sda   (i2c_sda)
  );

  always #5 CLK = ~CLK;

  typedef enum int {K_STR, K_DRR, K_BUS} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    logic [15:0] exp;
    logic [15:0] mask;
    logic [15:0] act;
  } chk_t;

  chk_t       scq[$];
  logic [7:0] rxq[$];
  event       chk_ev;
  int         n_checks = 0;
  int         n_errors = 0;
  logic       rx_prev  = 1'b0;

  // Scoreboard: pops every queued expectation when a sample point is signalled.
  initial begin
    chk_t        c;
    logic [15:0] a;
    forever begin
      @(chk_ev);
      while (scq.size() != 0) begin
        c = scq.pop_front();
        case (c.kind)
          K_STR:   a = I2CSTR;
          K_DRR:   a = I2CDRR;
          default: a = c.act;
        endcase
        n_checks++;
        if ((a & c.mask) !== (c.exp & c.mask)) begin
          n_errors++;
          $display("FAIL %s: actual %h expected %h (mask %h)", c.name, a, c.exp, c.mask);
        end
      end
    end
  end

  // Every RRDY rise is a byte commit and must match the next expected byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      if (I2CSTR[3] && !rx_prev) begin
        n_checks++;
        if (rxq.size() == 0) begin
          n_errors++;
          $display("FAIL rx_commit: actual I2CDRR %h expected no commit", I2CDRR);
        end else begin
          e = rxq.pop_front();
          if (I2CDRR !== {8'h00, e}) begin
            n_errors++;
            $display("FAIL rx_commit: actual I2CDRR %h expected %h", I2CDRR, {8'h00, e});
          end
        end
      end
      rx_prev = I2CSTR[3];
    end
  end

  task automatic push(input string nm, input kind_t k, input logic [15:0] e,
                      input logic [15:0] m, input logic [15:0] a);
    chk_t c;
    c.name = nm; c.kind = k; c.exp = e; c.mask = m; c.act = a;
    scq.push_back(c);
    ->chk_ev;
  endtask

  task automatic exp_str(input string nm, input logic [15:0] e, input logic [15:0] m);
    push(nm, K_STR, e, m, 16'h0000);
  endtask

  task automatic exp_drr(input string nm, input logic [15:0] e);
    push(nm, K_DRR, e, 16'hFFFF, 16'h0000);
  endtask

  task automatic obs(input string nm, input logic [15:0] e, input logic [15:0] a);
    push(nm, K_BUS, e, 16'hFFFF, a);
  endtask

  task automatic m_start();
    m_sda_low = 1'b1; #Q;
    i2c_scl   = 1'b0;
  endtask

  task automatic m_stop();
    #Q m_sda_low = 1'b1;
    #Q i2c_scl   = 1'b1;
    #Q m_sda_low = 1'b0;
    #Q;
  endtask

  task automatic m_wbit(input logic b);
    #Q m_sda_low = ~b;
    #Q i2c_scl   = 1'b1;
    #(2*Q) i2c_scl = 1'b0;
  endtask

  task automatic m_rbit(output logic b);
    #Q m_sda_low = 1'b0;
    #Q i2c_scl   = 1'b1;
    #Q b         = i2c_sda;
    #Q i2c_scl   = 1'b0;
  endtask

  task automatic m_wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) m_wbit(d[i]);
    m_rbit(ack);
  endtask

  task automatic m_rbyte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      m_rbit(b);
      d[i] = b;
    end
    m_wbit(nack);
  endtask

  task automatic wr(input string nm, input logic [7:0] d, input logic exp_ack);
    logic a;
    m_wbyte(d, a);
    obs(nm, {15'd0, exp_ack}, {15'd0, a});
  endtask

  task automatic host_write(input logic [7:0] d);
    @(negedge CLK);
    I2CDXR    = {8'h00, d};
    din_write = 1'b1;
    @(negedge CLK);
    din_write = 1'b0;
  endtask

  task automatic host_read();
    @(negedge CLK);
    dout_read = 1'b1;
    @(negedge CLK);
    dout_read = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual time limit reached, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    I2COAR    = 16'h0050;
    I2CDXR    = 16'h0000;
    din_write = 1'b0;
    dout_read = 1'b0;
    i2c_scl   = 1'b1;
    m_sda_low = 1'b0;
    reset     = 1'b0;
    #20;
    exp_str("reset_status", 16'h0010, 16'hFFFF);
    exp_drr("reset_drr", 16'h0000);
    #10 reset = 1'b1;
    #(2*Q);

    // Master write of one byte, then STOP
    m_start();
    wr("w_addr_ack", 8'hA0, 1'b0);
    exp_str("w_addr_status", 16'h1210, 16'hFFFF);
    rxq.push_back(8'h3C);
    wr("w_data_ack", 8'h3C, 1'b0);
    m_stop();
    #(2*Q);
    exp_str("w_stop_status", 16'h0238, 16'hFFFF);
    exp_drr("w_drr", 16'h003C);
    host_read();
    #(2*Q);

    // Master read of two bytes, second NACKed
    host_write(8'h5A);
    m_start();
    wr("r_addr_ack", 8'hA1, 1'b0);
    fork
      m_rbyte(d, 1'b0);
      begin
        for (int k = 0; k < 64 && !I2CSTR[4]; k++) @(negedge CLK);
        obs("r_xrdy_on_load", 16'h0001, {15'd0, I2CSTR[4]});
        host_write(8'hC3);
      end
    join
    obs("r_byte0", 16'h005A, {8'h00, d});
    m_rbyte(d, 1'b1);
    obs("r_byte1", 16'h00C3, {8'h00, d});
    m_stop();
    #(2*Q);
    exp_str("r_stop_status", 16'h4232, 16'hFFFF);

    // Foreign address is never acknowledged
    m_start();
    wr("nomatch_addr_nack", 8'hA2, 1'b1);
    exp_str("nomatch_status", 16'h1010, 16'hBFFF);
    wr("nomatch_data_nack", 8'h00, 1'b1);
    m_stop();
    #(2*Q);
    exp_str("nomatch_stop_status", 16'h0030, 16'hBFFF);

    // Second byte without dout_read overruns
    m_start();
    wr("ovr_addr_ack", 8'hA0, 1'b0);
    rxq.push_back(8'h11);
    wr("ovr_byte0_ack", 8'h11, 1'b0);
    wr("ovr_byte1_nack", 8'h22, 1'b1);
    exp_str("ovr_status", 16'h1A18, 16'hFFFF);
    exp_drr("ovr_drr", 16'h0011);
    m_stop();
    host_read();
    #(2*Q);

    // Read with an empty transmit buffer underflows
    m_start();
    wr("unf_addr_ack", 8'hA1, 1'b0);
    m_rbyte(d, 1'b1);
    obs("unf_byte", 16'h00FF, {8'h00, d});
    m_stop();
    #(2*Q);
    exp_str("unf_status", 16'h4632, 16'hFFFF);

    // General call write
    m_start();
    wr("gc_addr_ack", 8'h00, 1'b0);
    exp_str("gc_status", 16'h1110, 16'hFDFF);
    rxq.push_back(8'h77);
    wr("gc_data_ack", 8'h77, 1'b0);
    m_stop();
    #(2*Q);
    exp_drr("gc_drr", 16'h0077);
    host_read();
    #(2*Q);

    // Reset during the 4th data bit of a write (byte 0xB0)
    m_start();
    wr("rst_addr_ack", 8'hA0, 1'b0);
    m_wbit(1'b1);
    m_wbit(1'b0);
    m_wbit(1'b1);
    #Q m_sda_low = 1'b0;
    #Q i2c_scl   = 1'b1;
    #23 reset    = 1'b0;
    #1;
    exp_str("rst_status", 16'h0010, 16'hFFFF);
    exp_drr("rst_drr", 16'h0000);
    obs("rst_sda_released", 16'h0001, {15'd0, i2c_sda});
    #6 reset = 1'b1;
    #10 i2c_scl = 1'b0;
    m_stop();
    #(2*Q);
    exp_str("rst_stop_status", 16'h0030, 16'hFFFF);
    m_start();
    wr("post_rst_addr_ack", 8'hA0, 1'b0);
    rxq.push_back(8'h5E);
    wr("post_rst_data_ack", 8'h5E, 1'b0);
    m_stop();
    #(2*Q);
    exp_drr("post_rst_drr", 16'h005E);
    #(2*Q);

    n_checks++;
    if (rxq.size() != 0) begin
      n_errors++;
      $display("FAIL rx_pending: actual %0d uncommitted bytes expected 0", rxq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_i2c_slave
`default_nettype wire
